// File: rtl/mem_readout_seq_pkg.sv
// Shared constants and FSM state type for the memory-merge readout sequencer.
// The select helper keeps the encoder's sel encoding in one place.
package mem_readout_seq_pkg;

    localparam int         NBLK       = 12;
    localparam logic [3:0] SEL_FIRST  = 4'hF;
    localparam int         SEL_BASE   = 1;
    localparam int         SETTLE_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_PICK,
        ST_READ,
        ST_DONE
    } state_t;

    // True when sel names a real block (1..NBLK); 0, 13, 14 and SEL_FIRST are not blocks.
    function automatic logic sel_is_block(input logic [3:0] sel);
        return (sel != SEL_FIRST) && (sel >= 4'(SEL_BASE)) && (sel < 4'(SEL_BASE + NBLK));
    endfunction

endpackage

// File: rtl/mem_readout_seq_if.sv
// Memory read bus plus merged output stream between the sequencer and the memory blocks.
interface mem_readout_seq_if #(
    parameter int NBLK  = 12,
    parameter int IDX_W = 6,
    parameter int DAT_W = 36
);
    logic                    rd_en;
    logic [3:0]              rd_blk;
    logic [IDX_W-1:0]        rd_addr;
    logic [NBLK*DAT_W-1:0]   mem_dout;
    logic [DAT_W-1:0]        dout;
    logic                    dout_valid;

    modport master (
        output rd_en, rd_blk, rd_addr, dout, dout_valid,
        input  mem_dout
    );

    modport slave (
        input  rd_en, rd_blk, rd_addr, dout, dout_valid,
        output mem_dout
    );
endinterface

// File: rtl/mem_readout_seq_out_mux.sv
// Registered NBLK:1 data mux: captures the slice of the block being read and
// flags it valid one cycle after the read strobe.
module readout_out_mux #(
    parameter int NBLK  = 12,
    parameter int DAT_W = 36
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [3:0]            rd_blk,
    input  logic [NBLK*DAT_W-1:0] mem_dout,
    output logic [DAT_W-1:0]      dout,
    output logic                  dout_valid
);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of its neighbours; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_en;
            if (rd_en) begin
                dout <= mem_dout[rd_blk*DAT_W +: DAT_W];
            end
        end
    end

endmodule

// File: rtl/mem_readout_seq.sv
// Readout sequencer: loads per-block counts into the priority encoder, then drains
// each non-empty block in encoder order and pulses done when all are empty.
module mem_readout_seq #(
    parameter int NBLK  = mem_readout_seq_pkg::NBLK,
    parameter int IDX_W = 6,
    parameter int DAT_W = 36
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NBLK*(IDX_W+1)-1:0]   nent,
    output logic                        first_dat,
    output logic [NBLK-1:0]             has_dat,
    input  logic [3:0]                  sel,
    input  logic                        none,
    mem_readout_seq_if.master           bus,
    output logic                        busy,
    output logic                        done
);
    import mem_readout_seq_pkg::*;

    localparam int                CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(1 << IDX_W);

    state_t           state;
    logic [CNT_W-1:0] cnt [NBLK];
    logic [1:0]       settle_cnt;
    logic [CNT_W-1:0] last_idx;
    logic             last_beat;

    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    assign last_idx  = cnt[bus.rd_blk] - CNT_W'(1);
    assign last_beat = ({1'b0, bus.rd_addr} == last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            first_dat   <= 1'b0;
            has_dat     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_blk  <= '0;
            bus.rd_addr <= '0;
            settle_cnt  <= '0;
            // NOTE: the count table is a handful of flops, not a RAM, so clearing it
            // in reset is cheap and keeps the read-end compare defined after reset.
            for (int k = 0; k < NBLK; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        first_dat <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    first_dat  <= 1'b0;
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                    for (int k = 0; k < NBLK; k++) begin
                        cnt[k]     <= clamp_cnt(nent[k*CNT_W +: CNT_W]);
                        has_dat[k] <= (nent[k*CNT_W +: CNT_W] != '0);
                    end
                end
                ST_SETTLE: begin
                    // Wait out the encoder's two register stages before trusting sel.
                    if (settle_cnt == 2'(SETTLE_CYC - 1)) begin
                        state <= ST_PICK;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ST_PICK: begin
                    if (none) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (sel_is_block(sel)) begin
                        state       <= ST_READ;
                        bus.rd_en   <= 1'b1;
                        bus.rd_blk  <= sel - 4'(SEL_BASE);
                        bus.rd_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (last_beat) begin
                        bus.rd_en            <= 1'b0;
                        has_dat[bus.rd_blk]  <= 1'b0;
                        settle_cnt           <= '0;
                        state                <= ST_SETTLE;
                    end else begin
                        bus.rd_addr <= bus.rd_addr + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    readout_out_mux #(
        .NBLK  (NBLK),
        .DAT_W (DAT_W)
    ) u_out_mux (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (bus.rd_en),
        .rd_blk     (bus.rd_blk),
        .mem_dout   (bus.mem_dout),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid)
    );

endmodule

// File: tb/tb_mem_readout_seq.sv
// Scoreboard bench: a two-stage priority-encoder model and a {blk,idx} memory pattern
// sit around the sequencer; expected reads, beats and done times are queued at launch.
module tb_mem_readout_seq;

    localparam int NB = 12;
    localparam int IW = 6;
    localparam int DW = 36;
    localparam int CW = IW + 1;

    typedef struct {
        logic [3:0]    blk;
        logic [IW-1:0] addr;
        int            t;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [NB*CW-1:0] nent = '0;
    logic             first_dat;
    logic [NB-1:0]    has_dat;
    logic [3:0]       sel;
    logic             none;
    logic             busy;
    logic             done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   done_cnt = 0;
    exp_t rd_q[$];
    exp_t dv_q[$];
    int   done_q[$];
    exp_t mon_e;
    int   mon_t;

    mem_readout_seq_if #(.NBLK(NB), .IDX_W(IW), .DAT_W(DW)) bus ();

    mem_readout_seq #(.NBLK(NB), .IDX_W(IW), .DAT_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .nent      (nent),
        .first_dat (first_dat),
        .has_dat   (has_dat),
        .sel       (sel),
        .none      (none),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: first_dat wins (sel 15), else lowest set flag k gives k+1, else none.
    function automatic logic [4:0] enc(input logic f, input logic [NB-1:0] h);
        if (f) return {1'b0, 4'hF};
        for (int k = 0; k < NB; k++) begin
            if (h[k]) return {1'b0, 4'(k + 1)};
        end
        return {1'b1, 4'h0};
    endfunction

    logic [4:0] enc_s1, enc_s2;
    always @(posedge clk) begin
        if (reset) begin
            enc_s1 <= {1'b1, 4'h0};
            enc_s2 <= {1'b1, 4'h0};
        end else begin
            enc_s1 <= enc(first_dat, has_dat);
            enc_s2 <= enc_s1;
        end
    end
    assign sel  = enc_s2[3:0];
    assign none = enc_s2[4];

    always_comb begin
        bus.mem_dout = '0;
        for (int k = 0; k < NB; k++) begin
            bus.mem_dout[k*DW +: DW] = DW'({4'(k), bus.rd_addr});
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, $time);
        end
    endtask

    // Monitor: labels each sample with the edge that would capture it.
    always @(negedge clk) begin
        mon_t = cyc + 1;
        if (bus.rd_en === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: got blk %0d addr %0d at %0d, none queued", bus.rd_blk, bus.rd_addr, mon_t);
            end else begin
                mon_e = rd_q.pop_front();
                check("rd_beat", {32'(mon_t), bus.rd_blk, bus.rd_addr}, {32'(mon_e.t), mon_e.blk, mon_e.addr});
            end
        end
        if (bus.dout_valid === 1'b1) begin
            if (dv_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dout_unexpected: got %0h at %0d, none queued", bus.dout, mon_t);
            end else begin
                mon_e = dv_q.pop_front();
                check("dout_beat", {32'(mon_t), bus.dout}, {32'(mon_e.t + 1), DW'({mon_e.blk, mon_e.addr})});
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got done at %0d, none queued", mon_t);
            end else begin
                check("done_time", 32'(mon_t), 32'(done_q.pop_front()));
            end
        end
    end

    function automatic logic [NB*CW-1:0] one_cnt(input int k, input int v);
        logic [NB*CW-1:0] r;
        r = '0;
        r[k*CW +: CW] = CW'(v);
        return r;
    endfunction

    // Pushes the hand-derived schedule, pulses start, and checks LOAD / has_dat.
    task automatic launch(input logic [NB*CW-1:0] n);
        int t;
        int c;
        logic [NB-1:0] mask;
        @(negedge clk);
        nent  = n;
        start = 1'b1;
        t0    = cyc + 1;
        t     = t0 + 5;
        mask  = '0;
        for (int k = 0; k < NB; k++) begin
            c = int'(n[k*CW +: CW]);
            if (c > 64) c = 64;
            if (c > 0) begin
                mask[k] = 1'b1;
                for (int i = 0; i < c; i++) begin
                    rd_q.push_back('{4'(k), IW'(i), t});
                    dv_q.push_back('{4'(k), IW'(i), t});
                    t++;
                end
                t += 3;
            end
        end
        done_q.push_back(t);
        @(negedge clk);
        start = 1'b0;
        check("load_first_busy", {first_dat, busy}, 2'b11);
        @(negedge clk);
        check("has_dat_loaded", {first_dat, has_dat}, {1'b0, mask});
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == n0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        repeat (4) @(negedge clk);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("dv_q_drained", 32'(dv_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        check("idle_after_done", {busy, has_dat}, '0);
        rd_q.delete();
        dv_q.delete();
        done_q.delete();
    endtask

    logic [NB*CW-1:0] all_ones;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {first_dat, has_dat, bus.rd_en, bus.rd_blk, bus.rd_addr,
                                bus.dout, bus.dout_valid, busy, done}, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Blocks 0 and 2 non-empty.
        launch(one_cnt(0, 3) | one_cnt(2, 2));
        wait_done(100);

        // Everything empty: no reads, done at T+5.
        launch('0);
        wait_done(50);

        // Count 100 clamps to 64 on block 11.
        launch(one_cnt(11, 100));
        wait_done(200);

        // One entry in every block, read in ascending order.
        all_ones = '0;
        for (int k = 0; k < NB; k++) all_ones |= one_cnt(k, 1);
        launch(all_ones);
        wait_done(200);

        // start pulse in READ is ignored.
        launch(one_cnt(0, 3) | one_cnt(2, 2));
        repeat (4) @(negedge clk);
        check("in_read_before_start", {busy, bus.rd_en}, 2'b11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        repeat (10) @(negedge clk);
        check("no_second_event", {busy, 32'(done_cnt)}, {1'b0, 32'd5});

        // Reset while block 2 idx 1 is on the bus.
        launch(one_cnt(2, 5));
        repeat (4) @(negedge clk);
        check("reset_point", {bus.rd_en, bus.rd_blk, bus.rd_addr}, {1'b1, 4'd2, 6'd1});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid_read", {first_dat, has_dat, bus.rd_en, bus.rd_blk, bus.rd_addr,
                                 bus.dout, bus.dout_valid, busy, done}, '0);
        repeat (3) @(negedge clk);
        check("reset_no_more_reads", {busy, bus.dout_valid, 32'(rd_q.size())}, {2'b00, 32'd3});
        check("reset_dropped_beats", {32'(dv_q.size()), 32'(done_q.size())}, {32'd4, 32'd1});
        rd_q.delete();
        dv_q.delete();
        done_q.delete();

        // Clean event after the reset.
        launch(one_cnt(5, 2) | one_cnt(7, 1));
        wait_done(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
